// File: rtl/input_layer_stream_feeder_if.sv
// Purpose : bus bundle between the upstream state-vector source / weight loader and the
//           input-layer stream feeder, plus the broadcast beat bus towards the nodes.
// Signals : i_valid/i_state/o_ready   - state-vector offer handshake
//           i_w_wr_en/i_w_node/i_w_index/i_w_data - weight-table write port
//           o_valid/o_data/o_weight/o_last        - per-beat broadcast to the node array
// Modports: master = upstream side, slave = feeder.
interface input_layer_stream_feeder_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 3,
  parameter int unsigned NUM_NODES  = 64
);
  localparam int unsigned NODE_W  = (NUM_NODES  > 1) ? $clog2(NUM_NODES)  : 1;
  localparam int unsigned INDEX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic                               i_valid;
  logic [NUM_INPUTS*DATA_WIDTH-1:0]   i_state;
  logic                               o_ready;
  logic                               i_w_wr_en;
  logic [NODE_W-1:0]                  i_w_node;
  logic [INDEX_W-1:0]                 i_w_index;
  logic [DATA_WIDTH-1:0]              i_w_data;
  logic                               o_valid;
  logic [DATA_WIDTH-1:0]              o_data;
  logic [NUM_NODES*DATA_WIDTH-1:0]    o_weight;
  logic                               o_last;

  modport master (
    output i_valid, i_state, i_w_wr_en, i_w_node, i_w_index, i_w_data,
    input  o_ready, o_valid, o_data, o_weight, o_last
  );

  modport slave (
    input  i_valid, i_state, i_w_wr_en, i_w_node, i_w_index, i_w_data,
    output o_ready, o_valid, o_data, o_weight, o_last
  );
endinterface

// File: rtl/input_layer_stream_feeder.sv
// Purpose : holds the input-layer weight table, captures one state vector per frame and
//           streams it one element per cycle, broadcasting each element together with the
//           matching weight of every node. Frames may run back-to-back without a bubble.
// Ports   : clk  - clock
//           rst  - synchronous active-high reset
//           bus  - slave side of input_layer_stream_feeder_if (handshake, weight write port,
//                  registered beat outputs; o_ready is combinational)
module input_layer_stream_feeder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 3,
  parameter int unsigned NUM_NODES  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input_layer_stream_feeder_if.slave  bus
);
  localparam int unsigned CNT_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned NODE_W = (NUM_NODES  > 1) ? $clog2(NUM_NODES)  : 1;
  localparam int unsigned VEC_W  = NUM_INPUTS * DATA_WIDTH;
  localparam int unsigned WGT_W  = NUM_NODES * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_INPUTS - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic [VEC_W-1:0]        state_buf_q, state_buf_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [WGT_W-1:0]        weight_q, weight_d;
  logic [DATA_WIDTH-1:0]   w_tab_q [NUM_NODES][NUM_INPUTS];

  logic                    ready_c;
  logic                    accept_c;
  logic                    emit_c;
  logic [VEC_W-1:0]        src_c;
  logic                    node_ok_c;
  logic                    index_ok_c;

  // Ready in IDLE, or while the final beat of a frame is on the bus (back-to-back frames)
  assign ready_c  = !rst && ((state_q == IDLE) || (beat_q == LAST_BEAT));
  assign accept_c = bus.i_valid && ready_c;

  // Out-of-range write addresses are dropped; a full power-of-two range needs no check
  if (NUM_NODES == (1 << NODE_W)) begin : g_node_full
    assign node_ok_c = 1'b1;
  end else begin : g_node_part
    assign node_ok_c = (bus.i_w_node < NODE_W'(NUM_NODES));
  end
  if (NUM_INPUTS == (1 << CNT_W)) begin : g_index_full
    assign index_ok_c = 1'b1;
  end else begin : g_index_part
    assign index_ok_c = (bus.i_w_index < CNT_W'(NUM_INPUTS));
  end

  // Next-state and beat generation
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    state_buf_d = state_buf_q;
    emit_c      = 1'b0;
    src_c       = state_buf_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    data_d      = data_q;
    weight_d    = weight_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d     = STREAM;
          beat_d      = '0;
          state_buf_d = bus.i_state;
          src_c       = bus.i_state;
          emit_c      = 1'b1;
        end
      end
      STREAM: begin
        if (beat_q == LAST_BEAT) begin
          if (accept_c) begin
            beat_d      = '0;
            state_buf_d = bus.i_state;
            src_c       = bus.i_state;
            emit_c      = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          beat_d = beat_q + CNT_W'(1);
          emit_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // First beat comes straight from i_state since the buffer is loaded at the same edge
    if (emit_c) begin
      valid_d = 1'b1;
      last_d  = (beat_d == LAST_BEAT);
      data_d  = src_c[32'(beat_d)*DATA_WIDTH +: DATA_WIDTH];
      for (int unsigned j = 0; j < NUM_NODES; j++) begin
        weight_d[j*DATA_WIDTH +: DATA_WIDTH] = w_tab_q[j][beat_d];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      state_buf_q <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
      weight_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      state_buf_q <= state_buf_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      data_q      <= data_d;
      weight_q    <= weight_d;
    end
  end

  // Weight table; a beat registered at the write edge still sees the old word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < NUM_NODES; j++) begin
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
          w_tab_q[j][k] <= '0;
        end
      end
    end else if (bus.i_w_wr_en && node_ok_c && index_ok_c) begin
      w_tab_q[bus.i_w_node][bus.i_w_index] <= bus.i_w_data;
    end
  end

  assign bus.o_ready  = ready_c;
  assign bus.o_valid  = valid_q;
  assign bus.o_last   = last_q;
  assign bus.o_data   = data_q;
  assign bus.o_weight = weight_q;
endmodule

// File: tb/tb_input_layer_stream_feeder.sv
// Purpose : self-checking bench for input_layer_stream_feeder. A table of directed vectors
//           covers single, back-to-back and ignored-offer frames; hand-written sequences
//           cover mid-frame weight writes and mid-frame reset; a random phase is compared
//           against a queue-based reference model.
module tb_input_layer_stream_feeder;
  localparam int unsigned DW = 32;
  localparam int unsigned NI = 3;
  localparam int unsigned NN = 64;

  logic clk = 1'b0;
  logic rst;

  input_layer_stream_feeder_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_NODES(NN)) bus ();

  input_layer_stream_feeder #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_NODES(NN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: weight table plus a queue of beats still to be emitted
  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    k;
  } beat_t;

  logic [DW-1:0]    wm [NN][NI];
  beat_t            pend [$];
  logic             m_valid = 1'b0;
  logic             m_last  = 1'b0;
  logic [DW-1:0]    m_data  = '0;
  logic [NN*DW-1:0] m_w     = '0;

  typedef struct {
    logic          v;
    logic [NI*DW-1:0] st;
    logic          rdy;
    logic          ov;
    logic [DW-1:0] d;
    logic          l;
    logic [DW-1:0] w0;
    logic [DW-1:0] w63;
  } vec_t;

  vec_t tbl [15];

  // Small non-negative integer to IEEE-754 single
  function automatic logic [31:0] i2f(input int n);
    int e;
    if (n == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (n[b]) e = b;
    return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h007F_FFFF)};
  endfunction

  function automatic logic [NI*DW-1:0] mkst(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
    return {c, b, a};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [NI*DW-1:0] st, input logic rdy,
                               input logic ov, input logic [31:0] d, input logic l,
                               input logic [31:0] w0, input logic [31:0] w63);
    vec_t r;
    r.v = v; r.st = st; r.rdy = rdy; r.ov = ov; r.d = d; r.l = l; r.w0 = w0; r.w63 = w63;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [NN*DW-1:0] act,
                       input logic [NN*DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      for (int j = 0; j < NN; j++) begin
        if (act[j*DW +: DW] !== exp[j*DW +: DW]) begin
          $display("FAIL %s: node %0d got %h expected %h at %0t", nm, j,
                   act[j*DW +: DW], exp[j*DW +: DW], $time);
          break;
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [NI*DW-1:0] st, input logic wr,
                       input logic [5:0] nd, input logic [1:0] ix, input logic [31:0] wd);
    bus.i_valid   = v;
    bus.i_state   = st;
    bus.i_w_wr_en = wr;
    bus.i_w_node  = nd;
    bus.i_w_index = ix;
    bus.i_w_data  = wd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 6'd0, 2'd0, 32'h0);
  endtask

  // Model update for one clock edge, using the inputs held across that edge
  task automatic model_edge();
    beat_t b;
    if (rst) begin
      pend.delete();
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_data  = '0;
      m_w     = '0;
      for (int j = 0; j < NN; j++) for (int k = 0; k < NI; k++) wm[j][k] = '0;
    end else begin
      if (bus.i_valid && pend.size() == 0) begin
        for (int k = 0; k < NI; k++) begin
          b.d = bus.i_state[k*DW +: DW];
          b.k = 2'(k);
          pend.push_back(b);
        end
      end
      if (pend.size() != 0) begin
        b = pend.pop_front();
        m_valid = 1'b1;
        m_last  = (b.k == 2'(NI - 1));
        m_data  = b.d;
        for (int j = 0; j < NN; j++) m_w[j*DW +: DW] = wm[j][b.k];
      end else begin
        m_valid = 1'b0;
        m_last  = 1'b0;
      end
      if (bus.i_w_wr_en && bus.i_w_index < 2'(NI))
        wm[bus.i_w_node][bus.i_w_index] = bus.i_w_data;
    end
  endtask

  task automatic pre_edge();
    #1;
    chk("o_ready", 32'(bus.o_ready), 32'(!rst && pend.size() == 0));
  endtask

  task automatic post_edge();
    @(posedge clk);
    model_edge();
    #1;
    chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
    chk("o_last", 32'(bus.o_last), 32'(m_last));
    chk("o_data", bus.o_data, m_data);
    chk_w("o_weight", bus.o_weight, m_w);
  endtask

  task automatic tick();
    pre_edge();
    post_edge();
  endtask

  logic [NI*DW-1:0] st_s, st_a, st_b;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Load W[j][k] = j*3+k as float
    for (int j = 0; j < NN; j++) begin
      for (int k = 0; k < NI; k++) begin
        drive(1'b0, '0, 1'b1, 6'(j), 2'(k), i2f(j * 3 + k));
        tick();
      end
    end
    idle();

    st_s = mkst(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    st_a = mkst(32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000);
    st_b = mkst(32'h40E0_0000, 32'h4100_0000, 32'h4110_0000);

    // v, state, ready before edge, then o_valid/o_data/o_last/node0/node63 after edge
    tbl[0]  = mkv(1, st_s, 1, 1, 32'h3F80_0000, 0, 32'h0000_0000, 32'h433D_0000);
    tbl[1]  = mkv(0, '0,   0, 1, 32'h4000_0000, 0, 32'h3F80_0000, 32'h433E_0000);
    tbl[2]  = mkv(0, '0,   0, 1, 32'h4040_0000, 1, 32'h4000_0000, 32'h433F_0000);
    tbl[3]  = mkv(0, '0,   1, 0, 32'h0,         0, 32'h0,         32'h0);
    tbl[4]  = mkv(1, st_a, 1, 1, 32'h4080_0000, 0, 32'h0000_0000, 32'h433D_0000);
    tbl[5]  = mkv(1, st_b, 0, 1, 32'h40A0_0000, 0, 32'h3F80_0000, 32'h433E_0000);
    tbl[6]  = mkv(1, st_b, 0, 1, 32'h40C0_0000, 1, 32'h4000_0000, 32'h433F_0000);
    tbl[7]  = mkv(1, st_b, 1, 1, 32'h40E0_0000, 0, 32'h0000_0000, 32'h433D_0000);
    tbl[8]  = mkv(0, '0,   0, 1, 32'h4100_0000, 0, 32'h3F80_0000, 32'h433E_0000);
    tbl[9]  = mkv(0, '0,   0, 1, 32'h4110_0000, 1, 32'h4000_0000, 32'h433F_0000);
    tbl[10] = mkv(0, '0,   1, 0, 32'h0,         0, 32'h0,         32'h0);
    tbl[11] = mkv(1, st_s, 1, 1, 32'h3F80_0000, 0, 32'h0000_0000, 32'h433D_0000);
    tbl[12] = mkv(1, st_a, 0, 1, 32'h4000_0000, 0, 32'h3F80_0000, 32'h433E_0000);
    tbl[13] = mkv(0, '0,   0, 1, 32'h4040_0000, 1, 32'h4000_0000, 32'h433F_0000);
    tbl[14] = mkv(0, '0,   1, 0, 32'h0,         0, 32'h0,         32'h0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].st, 1'b0, 6'd0, 2'd0, 32'h0);
      pre_edge();
      chk($sformatf("tbl%0d_ready", i), 32'(bus.o_ready), 32'(tbl[i].rdy));
      post_edge();
      chk($sformatf("tbl%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_last", i), 32'(bus.o_last), 32'(tbl[i].l));
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_data", i), bus.o_data, tbl[i].d);
        chk($sformatf("tbl%0d_w0", i), bus.o_weight[0 +: DW], tbl[i].w0);
        chk($sformatf("tbl%0d_w63", i), bus.o_weight[63*DW +: DW], tbl[i].w63);
      end
    end

    // Weight write on the edge that registers beat 1: old word first, new word next frame
    drive(1'b1, st_s, 1'b0, 6'd0, 2'd0, 32'h0);
    tick();
    drive(1'b0, '0, 1'b1, 6'd5, 2'd1, 32'h3F00_0000);
    tick();
    chk("w5_old", bus.o_weight[5*DW +: DW], i2f(16));
    idle();
    tick();
    tick();
    drive(1'b1, st_s, 1'b0, 6'd0, 2'd0, 32'h0);
    tick();
    idle();
    tick();
    chk("w5_new", bus.o_weight[5*DW +: DW], 32'h3F00_0000);
    tick();
    tick();
    // Out-of-range input index is dropped
    drive(1'b0, '0, 1'b1, 6'd5, 2'd3, 32'hDEAD_BEEF);
    tick();
    drive(1'b1, st_s, 1'b0, 6'd0, 2'd0, 32'h0);
    tick();
    chk("w5_k0", bus.o_weight[5*DW +: DW], i2f(15));
    idle();
    tick();
    chk("w5_k1", bus.o_weight[5*DW +: DW], 32'h3F00_0000);
    tick();
    chk("w5_k2", bus.o_weight[5*DW +: DW], i2f(17));
    tick();

    // Reset on the edge that would register beat 2
    drive(1'b1, st_s, 1'b0, 6'd0, 2'd0, 32'h0);
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_last", 32'(bus.o_last), 32'h0);
    chk_w("rst_weight", bus.o_weight, '0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus.o_ready), 32'h1);
    tick();
    chk("no_beat_after_rst", 32'(bus.o_valid), 32'h0);
    drive(1'b1, st_s, 1'b0, 6'd0, 2'd0, 32'h0);
    tick();
    idle();
    for (int k = 0; k < NI; k++) begin
      chk_w("weights_cleared", bus.o_weight, '0);
      chk("beat_after_rst", 32'(bus.o_valid), 32'h1);
      if (k < NI - 1) tick();
    end
    tick();

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom},
            ($urandom_range(0, 2) == 0), 6'($urandom_range(0, 63)),
            2'($urandom_range(0, 3)), $urandom);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
